fc_lcc_tb_cmd_sequencer: RTL and testbench
==========================================

Name: fc_lcc_tb_cmd_sequencer

Overview:
- Sequences testbench service commands for the fuse-controller / LCC services logic.
- Two command sources share the single tb_service_cmd channel:
  - port 0: MCU-side mailbox decoder
  - port 1: Caliptra-core-side mailbox decoder
- Round-robin arbiter feeds a small FIFO; an issue FSM emits one single-cycle command pulse at a time.
- After each pulse the FSM enforces a guard gap. After the FC/LCC reset command it waits longer, so the 11-cycle reset pulse and any clock-bypass switch settle before the next force/release.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- GAP_CYCLES, 2, idle cycles after a normal command; >= 1
- RESET_HOLD, 12, idle cycles after RESET_CMD; must be >= 11
- RESET_CMD, 8'h10, command code treated as FC/LCC reset

Ports:
- clk  input  1  clock
- cptra_rst  input  1  synchronous active-high reset
- req0_valid  input  1  port 0 command valid
- req0_cmd  input  8  port 0 command code
- req0_ready  output  1  port 0 accepted this cycle
- req1_valid  input  1  port 1 command valid
- req1_cmd  input  8  port 1 command code
- req1_ready  output  1  port 1 accepted this cycle
- flush  input  1  synchronous FIFO clear
- tb_service_cmd_valid  output  1  one-cycle command strobe to services logic
- tb_service_cmd  output  8  command code, valid with strobe
- busy  output  1  FIFO non-empty or FSM not IDLE
- issued_cnt  output  16  commands issued, wraps at 16'hFFFF -> 0

Behaviour:
- Interface: one clock domain (clk). cptra_rst is synchronous and active-high; sampled on posedge clk only.
- Reset values:
  - all outputs 0; tb_service_cmd = 8'h00
  - FIFO empty; FSM in IDLE; round-robin pointer favours port 0; counters 0
- Handshake: a command transfers on the cycle reqN_valid && reqN_ready. Requesters hold valid and cmd stable until ready. ready is combinational from registered state plus valid.
- Arbitration:
  - at most one push per cycle
  - FIFO full, flush high or cptra_rst high -> both ready = 0
  - only one valid -> that port granted
  - both valid -> grant goes to the port not granted last; pointer updates only on an actual transfer
- FIFO:
  - ready depends on full only; no same-cycle pass-through when full, even if popping
  - push and pop in the same cycle when non-full and non-empty -> count unchanged
  - pointers log2(DEPTH) bits and wrap naturally
- flush:
  - empties the FIFO next cycle
  - any push presented that cycle is not accepted (ready = 0)
  - FSM state and its counter are not affected; an in-progress GAP/RST_WAIT completes
- FSM states:
  - IDLE: if FIFO non-empty, pop head into the output register -> ISSUE
  - ISSUE: tb_service_cmd_valid = 1 for exactly one cycle; issued_cnt += 1. Next state is RST_WAIT with counter = RESET_HOLD-1 if cmd == RESET_CMD, else GAP with counter = GAP_CYCLES-1.
  - GAP / RST_WAIT: decrement each cycle; at 0 -> IDLE
- Latency:
  - idle and empty: port handshake at edge T, strobe high during cycle T+2
  - back-to-back normal commands: strobes spaced GAP_CYCLES+2 cycles
  - after RESET_CMD: next strobe at least RESET_HOLD+2 cycles later
- tb_service_cmd holds its last value between strobes; consumers qualify with valid.
- busy = (state != IDLE) || FIFO non-empty.
- Reset mid-operation (any state): FIFO cleared, FSM -> IDLE, strobe deasserted the next cycle, pending gap discarded, issued_cnt cleared.

Test Plan:
- Reset, then port 0 sends 8'hA0 once -> strobe with cmd 8'hA0 exactly 2 cycles after the handshake. Strobe width 1; busy falls after GAP_CYCLES; issued_cnt = 1.
- Both ports valid continuously (p0 = 8'h01, p1 = 8'h02) for 6 transfers -> accepted order 01,02,01,02,01,02. Strobes in the same order, spaced 4 cycles apart with GAP_CYCLES = 2.
- Push 5 commands without stall while the FSM is blocked in RST_WAIT -> ready = 0 once DEPTH = 4 entries are held. No command lost or reordered; all drain after the wait.
- Issue 8'h10 then 8'h21 back to back -> strobe for 8'h21 no earlier than 14 cycles after the 8'h10 strobe.
- Fill FIFO with 3 entries, assert flush for one cycle with req0_valid high -> req0_ready = 0 that cycle and FIFO empty next cycle. The in-progress gap completes; no further strobes occur.
- Assert cptra_rst during RST_WAIT and while the FIFO holds 2 entries -> next cycle all outputs are 0, busy = 0 and issued_cnt = 0. A new command after reset issues with the 2-cycle latency.

Source files
------------

// File: rtl/fc_lcc_tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fc_lcc_tb_cmd_sequencer
//  Description : Merges testbench service commands from two mailbox decoders
//                (port 0 = MCU side, port 1 = Caliptra-core side) onto the
//                single tb_service_cmd channel. A round-robin arbiter pushes
//                into a small FIFO; an issue FSM emits one single-cycle strobe
//                per command and then enforces an idle guard gap. The gap is
//                longer after the FC/LCC reset command so that the reset pulse
//                and any clock-bypass switch settle before the next command.
//
//  Ports       : clk, cptra_rst (sync, active-high)
//                req0_valid/req0_cmd/req0_ready  - port 0 valid/ready channel
//                req1_valid/req1_cmd/req1_ready  - port 1 valid/ready channel
//                flush                           - synchronous FIFO clear
//                tb_service_cmd_valid/_cmd       - one-cycle command strobe
//                busy                            - FIFO non-empty or FSM busy
//                issued_cnt                      - wrapping issue counter
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_lcc_tb_cmd_sequencer #(
    parameter int         DEPTH      = 4,
    parameter int         GAP_CYCLES = 2,
    parameter int         RESET_HOLD = 12,
    parameter logic [7:0] RESET_CMD  = 8'h10
) (
    input  logic        clk,
    input  logic        cptra_rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_cmd,
    output logic        req1_ready,
    input  logic        flush,
    output logic        tb_service_cmd_valid,
    output logic [7:0]  tb_service_cmd,
    output logic        busy,
    output logic [15:0] issued_cnt
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CNTW     = AW + 1;
    localparam int HOLD_MAX = (RESET_HOLD > GAP_CYCLES) ? RESET_HOLD : GAP_CYCLES;
    // Counter only ever holds HOLD_MAX-1.
    localparam int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CNTW-1:0] c_FULL     = CNTW'(DEPTH);
    localparam logic [CW-1:0]   c_GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]   c_RST_LD   = CW'(RESET_HOLD - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_GAP      = 2'd2;
    localparam logic [1:0] c_RST_WAIT = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    // 1 when port 1 won the last transfer; reset value makes port 0 favoured
    logic            r_last_p1;

    // Issue FSM
    logic [1:0]      r_state;
    logic [CW-1:0]   r_ctr;
    logic [7:0]      r_cmd;
    logic            r_valid;
    logic [15:0]     r_issued;

    logic            w_full;
    logic            w_empty;
    logic            w_can_push;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_push_data;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    // Readiness depends on full only; a pop in the same cycle does not free
    // a slot early.
    assign w_can_push = !w_full && !flush && !cptra_rst;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_can_push) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_p1;
                w_grant1 = !r_last_p1;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_push      = w_grant0 || w_grant1;
    assign w_push_data = w_grant1 ? req1_cmd : req0_cmd;
    assign w_pop       = (r_state == c_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_p1 <= 1'b1;
        end else begin
            if (w_push) begin
                r_last_p1 <= w_grant1;
            end
            if (flush) begin
                // Push is already blocked; a pop this cycle still reaches the
                // FSM, the rest of the queue is discarded.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNTW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_state  <= c_IDLE;
            r_ctr    <= '0;
            r_cmd    <= 8'h00;
            r_valid  <= 1'b0;
            r_issued <= 16'h0000;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= r_mem[r_rd_ptr];
                        r_valid <= 1'b1;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_issued <= r_issued + 16'd1;
                    if (r_cmd == RESET_CMD) begin
                        r_state <= c_RST_WAIT;
                        r_ctr   <= c_RST_LD;
                    end else begin
                        r_state <= c_GAP;
                        r_ctr   <= c_GAP_LD;
                    end
                end
                c_GAP, c_RST_WAIT: begin
                    if (r_ctr == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_ctr <= r_ctr - CW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign tb_service_cmd_valid = r_valid;
    assign tb_service_cmd       = r_cmd;
    assign issued_cnt           = r_issued;
    assign busy                 = (r_state != c_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fc_lcc_tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_lcc_tb_cmd_sequencer
//  Description : Self-checking bench for fc_lcc_tb_cmd_sequencer. A queue-based
//                reference model tracks the command backlog, the remaining
//                busy time of the issuer and the round-robin preference, and
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_lcc_tb_cmd_sequencer;

    localparam int         DEPTH   = 4;
    localparam int         GAP     = 2;
    localparam int         RH      = 12;
    localparam logic [7:0] RST_CMD = 8'h10;

    logic        clk = 1'b0;
    logic        cptra_rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_cmd = 8'h00;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_cmd = 8'h00;
    logic        req1_ready;
    logic        flush = 1'b0;
    logic        tb_service_cmd_valid;
    logic [7:0]  tb_service_cmd;
    logic        busy;
    logic [15:0] issued_cnt;

    fc_lcc_tb_cmd_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .RESET_HOLD (RH),
        .RESET_CMD  (RST_CMD)
    ) u_dut (
        .clk                  (clk),
        .cptra_rst            (cptra_rst),
        .req0_valid           (req0_valid),
        .req0_cmd             (req0_cmd),
        .req0_ready           (req0_ready),
        .req1_valid           (req1_valid),
        .req1_cmd             (req1_cmd),
        .req1_ready           (req1_ready),
        .flush                (flush),
        .tb_service_cmd_valid (tb_service_cmd_valid),
        .tb_service_cmd       (tb_service_cmd),
        .busy                 (busy),
        .issued_cnt           (issued_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: backlog queue, cycles the issuer stays non-idle,
    // pending strobe, last issued code, issue count, round-robin preference.
    logic [7:0]  q[$];
    int          busy_left = 0;
    bit          m_strobe = 1'b0;
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_issued = 16'h0000;
    bit          m_last_p1 = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit last_h0, last_h1, last_r0, last_r1;
    int hs_cyc0, hs_cyc1;
    int         s_cyc[$];
    logic [7:0] s_val[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rst, input bit fl, input logic [7:0] c0,
                              input logic [7:0] c1, input bit g0, input bit g1);
        bit pop;
        if (rst) begin
            q.delete();
            busy_left = 0;
            m_strobe  = 1'b0;
            m_cmd     = 8'h00;
            m_issued  = 16'h0000;
            m_last_p1 = 1'b1;
        end else begin
            pop = (busy_left == 0) && (q.size() > 0);
            if (m_strobe) m_issued = m_issued + 16'd1;
            m_strobe = 1'b0;
            if (busy_left > 0) busy_left--;
            if (pop) begin
                m_cmd     = q.pop_front();
                m_strobe  = 1'b1;
                busy_left = 1 + ((m_cmd == RST_CMD) ? RH : GAP);
            end
            if (fl) q.delete();
            if (g0) begin q.push_back(c0); m_last_p1 = 1'b0; end
            if (g1) begin q.push_back(c1); m_last_p1 = 1'b1; end
        end
    endtask

    // One clock cycle: check all outputs against the model, then advance it.
    task automatic tick();
        bit sp, g0, g1;
        #1;
        sp = !cptra_rst && !flush && (q.size() < DEPTH);
        g0 = sp && req0_valid && (!req1_valid || m_last_p1);
        g1 = sp && req1_valid && (!req0_valid || !m_last_p1);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("strobe", tb_service_cmd_valid, m_strobe);
        chk("cmd", tb_service_cmd, m_cmd);
        chk("busy", busy, (busy_left > 0) || (q.size() > 0));
        chk("issued_cnt", issued_cnt, m_issued);
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        last_h0 = req0_valid && req0_ready;
        last_h1 = req1_valid && req1_ready;
        if (last_h0) hs_cyc0 = cyc;
        if (last_h1) hs_cyc1 = cyc;
        if (tb_service_cmd_valid === 1'b1) begin
            s_cyc.push_back(cyc);
            s_val.push_back(tb_service_cmd);
        end
        @(posedge clk);
        model_edge(cptra_rst, flush, req0_cmd, req1_cmd, g0, g1);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        cptra_rst = 1'b1;
        tick();
        cptra_rst = 1'b0;
        s_cyc.delete();
        s_val.delete();
    endtask

    task automatic send0(input logic [7:0] c);
        int n = 0;
        req0_valid = 1'b1;
        req0_cmd   = c;
        do begin tick(); n++; end while (!last_h0 && n < 200);
        if (!last_h0) begin
            checks++; errors++;
            $error("FAIL send0_timeout: observed=no_handshake expected=handshake cmd=%0h", c);
        end
        req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] c, output int waited);
        int n = 0;
        req1_valid = 1'b1;
        req1_cmd   = c;
        do begin tick(); n++; end while (!last_h1 && n < 200);
        if (!last_h1) begin
            checks++; errors++;
            $error("FAIL send1_timeout: observed=no_handshake expected=handshake cmd=%0h", c);
        end
        waited = n - 1;
        req1_valid = 1'b0;
    endtask

    initial begin
        int hc, n, w;
        logic [7:0] acc[$];

        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        cptra_rst = 1'b0;
        #1;
        chk("rst_strobe", tb_service_cmd_valid, 0);
        chk("rst_cmd", tb_service_cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", issued_cnt, 0);

        // Single command latency and gap
        do_reset();
        send0(8'hA0);
        hc = hs_cyc0;
        idle(6);
        chk("t1_nstrobe", s_cyc.size(), 1);
        chk("t1_latency", s_cyc[0] - hc, 2);
        chk("t1_cmd", s_val[0], 8'hA0);
        chk("t1_busy", busy, 0);
        chk("t1_cnt", issued_cnt, 1);

        // Both ports valid: alternating grants and strobe spacing GAP+2
        do_reset();
        req0_valid = 1'b1; req0_cmd = 8'h01;
        req1_valid = 1'b1; req1_cmd = 8'h02;
        n = 0;
        for (int g = 0; g < 200 && n < 6; g++) begin
            tick();
            if (last_h0) begin acc.push_back(8'h01); n++; end
            if (last_h1) begin acc.push_back(8'h02); n++; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(30);
        chk("t2_naccepted", acc.size(), 6);
        chk("t2_nstrobe", s_cyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_accept_order", acc[i], (i % 2) ? 8'h02 : 8'h01);
            chk("t2_strobe_order", s_val[i], (i % 2) ? 8'h02 : 8'h01);
            if (i > 0) chk("t2_spacing", s_cyc[i] - s_cyc[i-1], GAP + 2);
        end

        // FIFO fills while issuer sits in the reset hold
        do_reset();
        send0(RST_CMD);
        n = 0;
        while (s_cyc.size() == 0 && n < 50) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            send1(8'h31 + 8'(i), w);
            if (i < 4) chk("t3_no_stall", w, 0);
            else       chk("t3_stalled", w > 0, 1);
        end
        idle(40);
        chk("t3_nstrobe", s_cyc.size(), 6);
        chk("t3_first", s_val[0], RST_CMD);
        for (int i = 1; i < 6; i++) chk("t3_order", s_val[i], 8'h30 + 8'(i));
        chk("t3_hold", s_cyc[1] - s_cyc[0] >= RH + 2, 1);

        // Reset command followed by a normal one
        do_reset();
        send0(RST_CMD);
        send0(8'h21);
        idle(25);
        chk("t4_cmd", s_val[1], 8'h21);
        chk("t4_hold", s_cyc[1] - s_cyc[0] >= RH + 2, 1);

        // Flush with three queued entries during a gap
        do_reset();
        send0(8'h41); send0(8'h42); send0(8'h43); send0(8'h44);
        flush = 1'b1; req0_valid = 1'b1; req0_cmd = 8'h55;
        tick();
        chk("t5_flush_ready", last_r0, 0);
        flush = 1'b0; req0_valid = 1'b0;
        #1;
        chk("t5_busy_after", busy, 0);
        idle(15);
        chk("t5_nstrobe", s_cyc.size(), 1);
        chk("t5_cnt", issued_cnt, 1);

        // Reset during the reset hold with two queued entries
        do_reset();
        send0(RST_CMD); send0(8'h61); send0(8'h62);
        idle(2);
        cptra_rst = 1'b1;
        tick();
        cptra_rst = 1'b0;
        #1;
        chk("t6_strobe", tb_service_cmd_valid, 0);
        chk("t6_cmd", tb_service_cmd, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", issued_cnt, 0);
        s_cyc.delete(); s_val.delete();
        send0(8'h77);
        hc = hs_cyc0;
        idle(6);
        chk("t6_latency", s_cyc[0] - hc, 2);
        chk("t6_new_cmd", s_val[0], 8'h77);
        chk("t6_new_cnt", issued_cnt, 1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            flush     = ($urandom_range(0, 39) == 0);
            cptra_rst = ($urandom_range(0, 299) == 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_cmd   = ($urandom_range(0, 5) == 0) ? RST_CMD : 8'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_cmd   = ($urandom_range(0, 5) == 0) ? RST_CMD : 8'($urandom);
            end
            tick();
            if (last_h0) req0_valid = 1'b0;
            if (last_h1) req1_valid = 1'b0;
        end
        flush = 1'b0; cptra_rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
